// File: rtl/iobus_pkg.sv
// Shared IO bus definitions for the MicroBlaze MCS IO bus blocks.
// Holds bus widths and the default read value returned for unmapped addresses.
package iobus_pkg;

    localparam int IO_DATA_W = 32;
    localparam int IO_ADDR_W = 32;

    localparam logic [IO_DATA_W-1:0] IO_DEFAULT_READ_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/iobus_sat_counter.sv
// Saturating up-counter with synchronous clear and sticky overflow flag.
// Ports: clk, rst_n (async, active low), inc, clr -> count[W-1:0], overflow.
module iobus_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         overflow
);

    localparam logic [W-1:0] MAX = '1;

    // Clear takes effect before a same-cycle increment.
    logic [W-1:0] w_base;
    logic         w_base_ovf;

    assign w_base     = clr ? '0 : count;
    assign w_base_ovf = clr ? 1'b0 : overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count    <= w_base;
            overflow <= w_base_ovf;
            if (inc) begin
                if (w_base == MAX) begin
                    overflow <= 1'b1;
                end else begin
                    count <= w_base + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/iobus_default_response.sv
// Catch-all IO bus responder: zero-wait ready, constant read data, miss diagnostics.
// Ports: clk, rst_n, io_* bus inputs, diag_clear -> io_read_data, io_ready, miss_* diagnostics.
module iobus_default_response
    import iobus_pkg::*;
#(
    parameter logic [IO_DATA_W-1:0] READ_DATA = IO_DEFAULT_READ_DATA,
    parameter int                   CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 io_addr_strobe,
    input  logic                 io_read_strobe,
    input  logic                 io_write_strobe,
    input  logic [IO_ADDR_W-1:0] io_address,
    input  logic                 diag_clear,
    output logic [IO_DATA_W-1:0] io_read_data,
    output logic                 io_ready,
    output logic [CNT_W-1:0]     miss_count,
    output logic [IO_ADDR_W-1:0] miss_last_addr,
    output logic                 miss_last_write,
    output logic                 miss_pulse,
    output logic                 miss_overflow
);

    // Only the write strobe matters for classification: neither strobe
    // set is recorded as a read, so the read strobe carries no information.
    logic w_unused_read_strobe;
    logic w_miss;

    assign w_unused_read_strobe = io_read_strobe;
    assign w_miss               = io_addr_strobe;

    // Bus path is purely combinational so it works even while in reset.
    assign io_ready     = io_addr_strobe;
    assign io_read_data = READ_DATA;

    iobus_sat_counter #(
        .W (CNT_W)
    ) u_miss_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (w_miss),
        .clr      (diag_clear),
        .count    (miss_count),
        .overflow (miss_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_last_addr  <= '0;
            miss_last_write <= 1'b0;
            miss_pulse      <= 1'b0;
        end else begin
            miss_pulse <= w_miss;
            if (diag_clear) begin
                miss_last_addr  <= '0;
                miss_last_write <= 1'b0;
            end
            // A coincident miss overrides the clear.
            if (w_miss) begin
                miss_last_addr  <= io_address;
                miss_last_write <= io_write_strobe;
            end
        end
    end

endmodule

// File: tb/tb_iobus_default_response.sv
// Scoreboard bench for iobus_default_response with a spec-level reference model.
// Stimulus pushes expected diagnostics per cycle; a monitor pops and compares.
module tb_iobus_default_response;

    localparam int          CW   = 4;
    localparam int unsigned MAXC = 15;

    typedef struct {
        int unsigned cnt;
        bit          ovf;
        logic [31:0] addr;
        bit          wr;
        bit          pulse;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          io_addr_strobe;
    logic          io_read_strobe;
    logic          io_write_strobe;
    logic [31:0]   io_address;
    logic          diag_clear;
    logic [31:0]   io_read_data;
    logic          io_ready;
    logic [CW-1:0] miss_count;
    logic [31:0]   miss_last_addr;
    logic          miss_last_write;
    logic          miss_pulse;
    logic          miss_overflow;

    int total = 0;
    int bad   = 0;
    bit clk_en = 0;
    bit done   = 0;

    exp_t q[$];
    exp_t m;

    iobus_default_response #(
        .CNT_W (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_address      (io_address),
        .diag_clear      (diag_clear),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .miss_count      (miss_count),
        .miss_last_addr  (miss_last_addr),
        .miss_last_write (miss_last_write),
        .miss_pulse      (miss_pulse),
        .miss_overflow   (miss_overflow)
    );

    initial begin
        clk = 0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_diag(string tag, exp_t e);
        chk({tag, ".count"}, 32'(miss_count), 32'(e.cnt));
        chk({tag, ".ovf"},   32'(miss_overflow), 32'(e.ovf));
        chk({tag, ".addr"},  miss_last_addr, e.addr);
        chk({tag, ".write"}, 32'(miss_last_write), 32'(e.wr));
        chk({tag, ".pulse"}, 32'(miss_pulse), 32'(e.pulse));
    endtask

    // Monitor: one expected entry per clock edge that consumed stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk_diag("mon", e);
            end
        end
    end

    task automatic model_reset();
        m.cnt   = 0;
        m.ovf   = 0;
        m.addr  = '0;
        m.wr    = 0;
        m.pulse = 0;
    endtask

    // Drive one access for the next edge and record its expected outcome.
    task automatic cycle(bit stb, bit rd, bit wr, logic [31:0] a, bit clr);
        @(posedge clk);
        #2;
        io_addr_strobe  = stb;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_address      = a;
        diag_clear      = clr;
        #1;
        chk("ready", 32'(io_ready), 32'(stb));
        chk("rdata", io_read_data, 32'hFFFF_FFFF);
        if (clr) begin
            m.cnt  = 0;
            m.ovf  = 0;
            m.addr = '0;
            m.wr   = 0;
        end
        m.pulse = stb;
        if (stb) begin
            if (m.cnt == MAXC) m.ovf = 1;
            else m.cnt = m.cnt + 1;
            m.addr = a;
            m.wr   = wr;
        end
        q.push_back(m);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, 0);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
        io_addr_strobe = 0;
        diag_clear     = 0;
        #1;
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n           = 0;
        io_addr_strobe  = 0;
        io_read_strobe  = 0;
        io_write_strobe = 0;
        io_address      = '0;
        diag_clear      = 0;
        model_reset();

        // Clock idle, in reset: bus path is combinational.
        #3;
        chk("rst_ready0", 32'(io_ready), 32'd0);
        chk("rst_rdata0", io_read_data, 32'hFFFF_FFFF);
        io_addr_strobe = 1;
        #3;
        chk("rst_ready1", 32'(io_ready), 32'd1);
        chk("rst_rdata1", io_read_data, 32'hFFFF_FFFF);
        io_addr_strobe = 0;
        #3;
        chk("rst_ready2", 32'(io_ready), 32'd0);
        chk_diag("reset", m);

        clk_en = 1;
        #12;
        rst_n = 1;
        idle(2);

        // Single read miss.
        cycle(1, 1, 0, 32'hC000_0010, 0);
        idle(2);

        // Three back-to-back write misses.
        cycle(1, 0, 1, 32'h1000_0000, 0);
        cycle(1, 0, 1, 32'h1000_0004, 0);
        cycle(1, 0, 1, 32'h1000_0008, 0);
        idle(1);

        // Saturation: clear, then 16 misses.
        cycle(0, 0, 0, 32'h0, 1);
        for (int i = 0; i < 16; i++)
            cycle(1, i[0], ~i[0], 32'h2000_0000 + 32'(i * 4), 0);
        @(posedge clk);
        #3;
        chk("sat.count", 32'(miss_count), 32'd15);
        chk("sat.ovf", 32'(miss_overflow), 32'd1);
        cycle(0, 0, 0, 32'h0, 1);
        idle(1);

        // Clear coincident with a miss.
        cycle(1, 0, 0, 32'h1234_5678, 0);
        cycle(1, 0, 1, 32'h8000_0004, 1);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), $urandom(),
                  ($urandom_range(0, 15) == 0));
        end

        // Reset mid-run with count 5.
        cycle(0, 0, 0, 32'h0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 32'hA000_0000 + 32'(i), 0);
        drain();
        chk("pre_rst.count", 32'(miss_count), 32'd5);
        rst_n = 0;
        model_reset();
        #1;
        chk_diag("async_rst", m);
        io_addr_strobe = 1;
        #1;
        chk("rst_mid_ready1", 32'(io_ready), 32'd1);
        @(posedge clk);
        #1;
        chk_diag("rst_hold", m);
        io_addr_strobe = 0;
        #1;
        chk("rst_mid_ready0", 32'(io_ready), 32'd0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 40; i++) begin
            cycle(bit'($urandom_range(0, 1)), 0, bit'($urandom_range(0, 1)),
                  $urandom(), ($urandom_range(0, 9) == 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        done = 1;
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: got no finish expected finish by 200000");
            $fatal(1);
        end
    end

endmodule
